// File: rtl/clk_div_multi_if.sv
// -----------------------------------------------------------------------------
// clk_div_multi_if
// Control and status bundle for the multi-channel clock divider.
//   I_clk_en        [NUM_CH]              per-channel enable
//   I_div_ratio     [NUM_CH*RATIO_WIDTH]  ratio slices, channel k at [k*RATIO_WIDTH +: RATIO_WIDTH]
//   I_ratio_load    [NUM_CH]              one-cycle strobe capturing that channel's ratio
//   o_div_clk       [NUM_CH]              divided clock per channel
//   o_tick          [NUM_CH]              one-cycle pulse at the start of each divided period
//   o_ratio_pending [NUM_CH]              a loaded ratio is waiting for its update point
// master: the side that drives the controls (testbench / register block).
// slave : the divider itself.
// -----------------------------------------------------------------------------
interface clk_div_multi_if #(
  parameter int RATIO_WIDTH = 8,
  parameter int NUM_CH      = 2
);
  logic [NUM_CH-1:0]             I_clk_en;
  logic [NUM_CH*RATIO_WIDTH-1:0] I_div_ratio;
  logic [NUM_CH-1:0]             I_ratio_load;
  logic [NUM_CH-1:0]             o_div_clk;
  logic [NUM_CH-1:0]             o_tick;
  logic [NUM_CH-1:0]             o_ratio_pending;

  modport master (
    output I_clk_en, I_div_ratio, I_ratio_load,
    input  o_div_clk, o_tick, o_ratio_pending
  );

  modport slave (
    input  I_clk_en, I_div_ratio, I_ratio_load,
    output o_div_clk, o_tick, o_ratio_pending
  );
endinterface

// File: rtl/clk_div_multi.sv
// -----------------------------------------------------------------------------
// clk_div_multi
// NUM_CH independent integer clock dividers running from one reference clock.
// Each channel has a shadow ratio that is applied only at a period boundary
// (or immediately while bypassed), so the divided clock never glitches.
//   I_ref_clk : reference clock, the only clock
//   I_rst_n   : asynchronous active-low reset
//   bus       : clk_div_multi_if.slave (enables, ratios, load strobes,
//               divided clocks, ticks, pending flags)
// Ratios 0 and 1, or a low enable, pass I_ref_clk straight through.
// -----------------------------------------------------------------------------
module clk_div_multi #(
  parameter int RATIO_WIDTH = 8,
  parameter int NUM_CH      = 2
) (
  input  logic          I_ref_clk,
  input  logic          I_rst_n,
  clk_div_multi_if.slave bus
);

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    logic [RATIO_WIDTH-1:0] r_shadow;
    logic [RATIO_WIDTH-1:0] r_ratio;
    logic [RATIO_WIDTH-1:0] r_cnt;
    logic                   r_pend;
    logic                   r_div;
    logic                   r_byp;
    logic                   r_tick;

    logic [RATIO_WIDTH-1:0] w_load_val;
    logic [RATIO_WIDTH-1:0] w_shadow_nxt;
    logic [RATIO_WIDTH-1:0] w_ratio_nxt;
    logic [RATIO_WIDTH-1:0] w_cnt_nxt;
    logic [RATIO_WIDTH:0]   w_high_len;
    logic                   w_pend_nxt;
    logic                   w_byp_nxt;
    logic                   w_div_nxt;
    logic                   w_tick_nxt;
    logic                   w_wrap;
    logic                   w_upd;

    assign w_load_val = bus.I_div_ratio[k*RATIO_WIDTH +: RATIO_WIDTH];

    always_comb begin
      w_shadow_nxt = r_shadow;
      w_pend_nxt   = r_pend;
      w_ratio_nxt  = r_ratio;
      w_cnt_nxt    = '0;
      w_div_nxt    = 1'b0;
      w_tick_nxt   = 1'b1;

      // Only meaningful in divide mode, where r_ratio is always >= 2.
      w_wrap = (r_cnt == r_ratio - RATIO_WIDTH'(1));
      // Bypass has no period to protect, so every edge is an update point.
      w_upd  = r_byp | w_wrap;

      if (bus.I_ratio_load[k]) begin
        w_shadow_nxt = w_load_val;
        if (w_upd) begin
          // Load landing on an update point is forwarded directly.
          w_ratio_nxt = w_load_val;
          w_pend_nxt  = 1'b0;
        end else begin
          w_pend_nxt  = 1'b1;
        end
      end else if (w_upd) begin
        if (r_pend) begin
          w_ratio_nxt = r_shadow;
        end
        w_pend_nxt = 1'b0;
      end

      w_byp_nxt  = !(bus.I_clk_en[k] && (w_ratio_nxt >= RATIO_WIDTH'(2)));
      w_high_len = ({1'b0, w_ratio_nxt} + (RATIO_WIDTH+1)'(1)) >> 1;

      if (w_byp_nxt) begin
        // Bypass: counter and level parked, every ref cycle is a period.
        w_cnt_nxt  = '0;
        w_div_nxt  = 1'b0;
        w_tick_nxt = 1'b1;
      end else if (r_byp) begin
        // Leaving bypass starts a full-length period.
        w_cnt_nxt  = '0;
        w_div_nxt  = 1'b1;
        w_tick_nxt = 1'b1;
      end else begin
        w_cnt_nxt  = w_wrap ? '0 : r_cnt + RATIO_WIDTH'(1);
        w_div_nxt  = ({1'b0, w_cnt_nxt} < w_high_len);
        w_tick_nxt = (w_cnt_nxt == '0);
      end
    end

    always_ff @(posedge I_ref_clk or negedge I_rst_n) begin
      if (!I_rst_n) begin
        r_shadow <= '0;
        r_pend   <= 1'b0;
        r_ratio  <= '0;
        r_cnt    <= '0;
        r_div    <= 1'b0;
        r_tick   <= 1'b0;
        r_byp    <= 1'b1;
      end else begin
        r_shadow <= w_shadow_nxt;
        r_pend   <= w_pend_nxt;
        r_ratio  <= w_ratio_nxt;
        r_cnt    <= w_cnt_nxt;
        r_div    <= w_div_nxt;
        r_tick   <= w_tick_nxt;
        r_byp    <= w_byp_nxt;
      end
    end

    // Both mux inputs are registers or the ref clock itself: no glitch source.
    assign bus.o_div_clk[k]       = r_byp ? I_ref_clk : r_div;
    assign bus.o_tick[k]          = r_tick;
    assign bus.o_ratio_pending[k] = r_pend;
  end

endmodule

// File: tb/tb_clk_div_multi.sv
module tb_clk_div_multi;
  localparam int RW = 8;
  localparam int NC = 2;

  logic ref_clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  clk_div_multi_if #(.RATIO_WIDTH(RW), .NUM_CH(NC)) bus_if ();

  clk_div_multi #(.RATIO_WIDTH(RW), .NUM_CH(NC)) dut (
    .I_ref_clk (ref_clk),
    .I_rst_n   (rst_n),
    .bus       (bus_if)
  );

  always #5 ref_clk = ~ref_clk;

  // Ratio 4 on ch0: 2 high / 2 low, tick on each rising edge.
  bit d4  [8]  = '{1,1,0,0,1,1,0,0};
  bit t4  [8]  = '{1,0,0,0,1,0,0,0};
  // Ratio 5 loaded at a wrap: 3 high / 2 low.
  bit d5  [10] = '{1,1,1,0,0,1,1,1,0,0};
  bit t5  [10] = '{1,0,0,0,0,1,0,0,0,0};
  // Ratio 6, then 3 loaded at cnt=1: 6-cycle period kept, then 2 high / 1 low.
  bit d63 [12] = '{1,1,1,0,0,0,1,1,0,1,1,0};
  bit t63 [12] = '{1,0,0,0,0,0,1,0,0,1,0,0};
  bit p63 [12] = '{0,0,1,1,1,1,0,0,0,0,0,0};
  // Two channels: ch0 ratio 4, ch1 ratio 7 with enable dropped at cnt=3.
  // bit1 = ch1, bit0 = ch0.
  logic [1:0] dpos [14] = '{2'b11,2'b11,2'b10,2'b10,2'b11,2'b11,2'b10,
                            2'b10,2'b11,2'b11,2'b00,2'b00,2'b01,2'b11};
  logic [1:0] dneg [14] = '{2'b11,2'b11,2'b10,2'b10,2'b01,2'b01,2'b10,
                            2'b10,2'b11,2'b11,2'b00,2'b00,2'b01,2'b11};
  logic [1:0] tk2  [14] = '{2'b11,2'b00,2'b00,2'b00,2'b11,2'b10,2'b10,
                            2'b00,2'b01,2'b00,2'b00,2'b00,2'b01,2'b10};

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge ref_clk);
    #1;
  endtask

  task automatic half();
    @(negedge ref_clk);
    #1;
  endtask

  task automatic set_ratio(input int ch, input logic [RW-1:0] val);
    bus_if.I_div_ratio[ch*RW +: RW] = val;
    bus_if.I_ratio_load[ch]         = 1'b1;
  endtask

  // ch0 in bypass: follows ref clock, tick held, nothing pending.
  task automatic chk_byp0(input string tag);
    chk({tag, "_hi"},   8'(bus_if.o_div_clk[0]),       8'd1);
    chk({tag, "_tick"}, 8'(bus_if.o_tick[0]),          8'd1);
    chk({tag, "_pend"}, 8'(bus_if.o_ratio_pending[0]), 8'd0);
    half();
    chk({tag, "_lo"},   8'(bus_if.o_div_clk[0]),       8'd0);
  endtask

  initial begin
    #20000;
    $display("FAIL timeout");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    rst_n                = 1'b0;
    bus_if.I_clk_en      = '0;
    bus_if.I_div_ratio   = '0;
    bus_if.I_ratio_load  = '0;

    // Reset state: ref-clock bypass, no tick, nothing pending.
    #2;
    chk("rst_div_lo", 8'(bus_if.o_div_clk),       8'h0);
    chk("rst_tick",   8'(bus_if.o_tick),          8'h0);
    chk("rst_pend",   8'(bus_if.o_ratio_pending), 8'h0);
    cyc();
    chk("rst_div_hi", 8'(bus_if.o_div_clk),       8'h3);
    chk("rst_tick2",  8'(bus_if.o_tick),          8'h0);
    #2;
    rst_n = 1'b1;

    // Ratio 4 on ch0.
    bus_if.I_clk_en[0] = 1'b1;
    set_ratio(0, 8'd4);
    for (int i = 0; i < 8; i++) begin
      cyc();
      bus_if.I_ratio_load = '0;
      chk("r4_div",  8'(bus_if.o_div_clk[0]),       8'(d4[i]));
      chk("r4_tick", 8'(bus_if.o_tick[0]),          8'(t4[i]));
      chk("r4_pend", 8'(bus_if.o_ratio_pending[0]), 8'd0);
    end

    // Ratio 5 loaded on the wrap edge: applied at once, pending never rises.
    set_ratio(0, 8'd5);
    for (int i = 0; i < 10; i++) begin
      cyc();
      bus_if.I_ratio_load = '0;
      chk("r5_div",  8'(bus_if.o_div_clk[0]),       8'(d5[i]));
      chk("r5_tick", 8'(bus_if.o_tick[0]),          8'(t5[i]));
      chk("r5_pend", 8'(bus_if.o_ratio_pending[0]), 8'd0);
    end

    // Ratio 6 (again at a wrap), then ratio 3 mid-period.
    set_ratio(0, 8'd6);
    for (int i = 0; i < 12; i++) begin
      cyc();
      bus_if.I_ratio_load = '0;
      chk("r63_div",  8'(bus_if.o_div_clk[0]),       8'(d63[i]));
      chk("r63_tick", 8'(bus_if.o_tick[0]),          8'(t63[i]));
      chk("r63_pend", 8'(bus_if.o_ratio_pending[0]), 8'(p63[i]));
      if (i == 1) set_ratio(0, 8'd3);
    end

    // Bypass cases: ratio 1, ratio 0, enable low (ratio 4 stored meanwhile).
    set_ratio(0, 8'd1);
    for (int i = 0; i < 2; i++) begin
      cyc();
      bus_if.I_ratio_load = '0;
      chk_byp0("byp_r1");
    end
    set_ratio(0, 8'd0);
    for (int i = 0; i < 2; i++) begin
      cyc();
      bus_if.I_ratio_load = '0;
      chk_byp0("byp_r0");
    end
    bus_if.I_clk_en[0] = 1'b0;
    set_ratio(0, 8'd4);
    for (int i = 0; i < 2; i++) begin
      cyc();
      bus_if.I_ratio_load = '0;
      chk_byp0("byp_en0");
    end

    // Two channels: ch0 ratio 4, ch1 ratio 7; ch1 enable dropped at cnt=3.
    bus_if.I_clk_en = 2'b11;
    set_ratio(1, 8'd7);
    for (int k = 0; k < 14; k++) begin
      cyc();
      bus_if.I_ratio_load = '0;
      chk("dual_div_pos", 8'(bus_if.o_div_clk),       8'(dpos[k]));
      chk("dual_tick",    8'(bus_if.o_tick),          8'(tk2[k]));
      chk("dual_pend",    8'(bus_if.o_ratio_pending), 8'h0);
      if (k == 3) bus_if.I_clk_en[1] = 1'b0;
      if (k == 5) bus_if.I_clk_en[1] = 1'b1;
      half();
      chk("dual_div_neg", 8'(bus_if.o_div_clk),       8'(dneg[k]));
    end

    // Leave a pending ratio on ch0, then reset mid-period.
    set_ratio(0, 8'd6);
    cyc();
    bus_if.I_ratio_load = '0;
    chk("pre_rst_pend", 8'(bus_if.o_ratio_pending), 8'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_div_hi", 8'(bus_if.o_div_clk),       8'h3);
    chk("mid_rst_tick",   8'(bus_if.o_tick),          8'h0);
    chk("mid_rst_pend",   8'(bus_if.o_ratio_pending), 8'h0);
    half();
    chk("mid_rst_div_lo", 8'(bus_if.o_div_clk),       8'h0);
    cyc();
    chk("mid_rst_hold",   8'(bus_if.o_div_clk),       8'h3);
    half();
    rst_n = 1'b1;

    // Enables still high but ratios cleared: stays in bypass until reload.
    cyc();
    chk("post_rst_div_hi", 8'(bus_if.o_div_clk),       8'h3);
    chk("post_rst_tick",   8'(bus_if.o_tick),          8'h3);
    chk("post_rst_pend",   8'(bus_if.o_ratio_pending), 8'h0);
    half();
    chk("post_rst_div_lo", 8'(bus_if.o_div_clk),       8'h0);

    set_ratio(0, 8'd4);
    for (int i = 0; i < 4; i++) begin
      cyc();
      bus_if.I_ratio_load = '0;
      chk("reload_div",   8'(bus_if.o_div_clk[0]), 8'(d4[i]));
      chk("reload_tick",  8'(bus_if.o_tick[0]),    8'(t4[i]));
      chk("reload_tick1", 8'(bus_if.o_tick[1]),    8'd1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
